fp_mul_seq: RTL

//  Sequential IEEE-754 floating-point multiplier; the multiply counterpart of the team's combinational divider.

---
 rtl/fp_mul_pkg.sv | 24 ++
 rtl/fp_mul_norm_round.sv | 69 ++++++
 rtl/fp_mul_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential FP multiplier.
// ROUND_NEAREST_EN selects round-to-nearest-even; undefined means truncation.
package fp_mul_pkg;

    localparam int unsigned FP_N = 23;
    localparam int unsigned FP_M = 8;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

`ifdef ROUND_NEAREST_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    function automatic int unsigned exp_bias(input int unsigned m);
        return (1 << (m - 1)) - 1;
    endfunction

    function automatic int unsigned exp_max(input int unsigned m);
        return (1 << m) - 1;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational normalise/round/range-check of the raw mantissa product.
// ROUND_NEAREST_EN adds guard/sticky round-to-nearest-even; otherwise truncates.
module fp_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter int unsigned N = FP_N,
    parameter int unsigned M = FP_M
) (
    input  logic [2*N+1:(ROUND_EN ? 0 : N)] acc_i,
    input  logic signed [M+1:0]             exp_i,
    input  logic                            sign_i,
    input  logic                            zero_i,
    output logic [N+M:0]                    c_o
);

    localparam logic signed [M+1:0] ONE_S     = 1;
    localparam logic signed [M+1:0] ZERO_S    = 0;
    localparam logic signed [M+1:0] EXP_MAX_S = (M+2)'(exp_max(M));

    logic [N-1:0]        frac;
    logic signed [M+1:0] e;
`ifdef ROUND_NEAREST_EN
    logic                guard;
    logic                sticky;
    logic [N:0]          rnd;
`endif

    always_comb begin
        frac = '0;
        e    = exp_i;
        c_o  = '0;
`ifdef ROUND_NEAREST_EN
        guard  = 1'b0;
        sticky = 1'b0;
        rnd    = '0;
`endif
        // product lies in [1,4): a set top bit means shift right by one
        if (acc_i[2*N+1]) begin
            frac = acc_i[2*N:N+1];
            e    = exp_i + ONE_S;
        end else begin
            frac = acc_i[2*N-1:N];
        end
`ifdef ROUND_NEAREST_EN
        if (acc_i[2*N+1]) begin
            guard  = acc_i[N];
            sticky = |acc_i[N-1:0];
        end else begin
            guard  = acc_i[N-1];
            sticky = |acc_i[N-2:0];
        end
        if (guard && (sticky || frac[0])) begin
            rnd  = {1'b0, frac} + (N+1)'(1);
            frac = rnd[N-1:0];
            if (rnd[N]) begin
                e = e + ONE_S;
            end
        end
`endif
        if (zero_i || (e <= ZERO_S)) begin
            c_o = {sign_i, {(N+M){1'b0}}};
        end else if (e >= EXP_MAX_S) begin
            c_o = {sign_i, {M{1'b1}}, {N{1'b0}}};
        end else begin
            c_o = {sign_i, e[M-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential shift-add IEEE-754 multiplier with valid/ready on both sides.
// Rounding mode selected by ROUND_NEAREST_EN (see fp_mul_norm_round).
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int unsigned N = FP_N,
    parameter int unsigned M = FP_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N+M:0] a,
    input  logic [N+M:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+M:0] c
);

    localparam int unsigned CW     = $clog2(N + 1) + 1;
    localparam int unsigned ACC_LO = ROUND_EN ? 0 : N;
    localparam logic signed [M+1:0] BIAS_S = (M+2)'(exp_bias(M));

    state_t              state_q;
    logic                sign_q;
    logic                zero_q;
    logic [2*N+1:0]      ma_q;
    logic [N:0]          mb_q;
    logic [2*N+1:0]      acc_q;
    logic [2*N+1:0]      acc_d;
    logic [CW-1:0]       count_q;
    logic signed [M+1:0] exp_q;
    logic signed [M+1:0] exp_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [N+M:0]        c_q;
    logic [N+M:0]        c_d;

    always_comb begin
        exp_d = $signed({2'b00, a[N+M-1:N]}) + $signed({2'b00, b[N+M-1:N]}) - BIAS_S;
        acc_d = mb_q[0] ? (acc_q + ma_q) : acc_q;
    end

    fp_mul_norm_round #(.N(N), .M(M)) u_norm (
        .acc_i  (acc_q[2*N+1:ACC_LO]),
        .exp_i  (exp_q),
        .sign_i (sign_q),
        .zero_i (zero_q),
        .c_o    (c_d)
    );

    // ma_q shifts left and mb_q right each MUL cycle, equivalent to mant_a<<count gated by mant_b[count]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= MUL;
                        in_ready_q <= 1'b0;
                        sign_q     <= a[N+M] ^ b[N+M];
                        zero_q     <= (a[N+M-1:N] == '0) || (b[N+M-1:N] == '0);
                        ma_q       <= {{(N+1){1'b0}}, 1'b1, a[N-1:0]};
                        mb_q       <= {1'b1, b[N-1:0]};
                        acc_q      <= '0;
                        count_q    <= '0;
                        exp_q      <= exp_d;
                    end
                end
                MUL: begin
                    acc_q   <= acc_d;
                    ma_q    <= ma_q << 1;
                    mb_q    <= mb_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(N)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    c_q         <= c_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule
